// File: rtl/gcd_pkg.sv
// Shared types for the GCD issuer: FSM state encoding and default watchdog limit.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/gcd_issuer.sv
// Initiator front end for the GCD core: one pair in flight, launch to core, watchdog, result hold.
// Latency: accept->core_start 1 cycle, done->out_valid 1 cycle, bypass 1 cycle; in_ready low until out handshake.
module gcd_issuer
  import gcd_pkg::*;
#(
  parameter int op_sz   = 8,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [op_sz-1:0] in_a,
  input  logic [op_sz-1:0] in_b,
  output logic [op_sz-1:0] core_a,
  output logic [op_sz-1:0] core_b,
  output logic             core_start,
  input  logic [op_sz-1:0] core_res,
  input  logic             core_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [op_sz-1:0] out_gcd,
  output logic [op_sz-1:0] out_a,
  output logic [op_sz-1:0] out_b,
  output logic             out_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [op_sz-1:0]  op_a, op_b;
  logic [op_sz-1:0]  res_q;
  logic              err_q;
  logic              start_q, valid_q;
  logic [CNT_W-1:0]  wd;

  logic              ld_op, ld_res, wd_clr, wd_inc, err_nxt;
  logic [op_sz-1:0]  res_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_op     = 1'b0;
    ld_res    = 1'b0;
    res_nxt   = '0;
    err_nxt   = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          ld_op = 1'b1;
          // Any zero operand is answered locally; the core only sees nonzero pairs.
          if (in_a == '0 && in_b == '0) begin
            ld_res    = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = HOLD;
          end else if (in_a == '0) begin
            ld_res    = 1'b1;
            res_nxt   = in_b;
            state_nxt = HOLD;
          end else if (in_b == '0) begin
            ld_res    = 1'b1;
            res_nxt   = in_a;
            state_nxt = HOLD;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        wd_clr    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done takes priority over an expiring watchdog in the same cycle
        if (core_done) begin
          ld_res    = 1'b1;
          res_nxt   = core_res;
          state_nxt = HOLD;
        end else if (wd == WD_LAST) begin
          ld_res    = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          wd_inc = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a    <= '0;
      op_b    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      wd      <= '0;
    end else begin
      if (ld_op) begin
        op_a <= in_a;
        op_b <= in_b;
      end
      if (ld_res) begin
        res_q <= res_nxt;
        err_q <= err_nxt;
      end
      if (wd_clr) begin
        wd <= '0;
      end else if (wd_inc) begin
        wd <= wd + 1'b1;
      end
      start_q <= (state_nxt == ISSUE);
      valid_q <= (state_nxt == HOLD);
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign core_a     = op_a;
  assign core_b     = op_b;
  assign core_start = start_q;
  assign out_valid  = valid_q;
  assign out_gcd    = res_q;
  assign out_a      = op_a;
  assign out_b      = op_b;
  assign out_err    = err_q;

endmodule

// File: tb/tb_gcd_issuer.sv
// Directed bench for gcd_issuer: instance 0 has a 16-cycle watchdog, instance 1 the default one.
module tb_gcd_issuer;

  logic       clk;
  logic       rst;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_a      [2];
  logic [7:0] in_b      [2];
  logic [7:0] core_a    [2];
  logic [7:0] core_b    [2];
  logic       core_start[2];
  logic [7:0] core_res  [2];
  logic       done_m    [2];
  logic       stray     [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_gcd   [2];
  logic [7:0] out_a     [2];
  logic [7:0] out_b     [2];
  logic       out_err   [2];
  logic       busy      [2];

  int lat [2];
  int cnt [2];
  bit run [2];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gcd_issuer #(
      .op_sz  (8),
      .TIMEOUT(g == 0 ? 16 : 1024),
      .CNT_W  (11)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .core_a    (core_a[g]),
      .core_b    (core_b[g]),
      .core_start(core_start[g]),
      .core_res  (core_res[g]),
      .core_done (done_m[g] | stray[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_gcd   (out_gcd[g]),
      .out_a     (out_a[g]),
      .out_b     (out_b[g]),
      .out_err   (out_err[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Core model: single done pulse lat cycles after start; lat==0 models a hung core.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      done_m[i] <= 1'b0;
      if (!rst) begin
        run[i] <= 1'b0;
        cnt[i] <= 0;
      end else if (core_start[i]) begin
        cnt[i] <= lat[i];
        run[i] <= (lat[i] != 0);
      end else if (run[i]) begin
        if (cnt[i] == 1) begin
          done_m[i]   <= 1'b1;
          core_res[i] <= ref_gcd(core_a[i], core_b[i]);
          run[i]      <= 1'b0;
        end else begin
          cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic run_pair(input int i, input logic [7:0] a, input logic [7:0] b, input int stall,
                          input logic [7:0] exp_g, input logic exp_e, input int exp_lat,
                          input bit exp_core);
    int k;
    int starts;
    bit seen;
    bit hold_bad;
    @(negedge clk);
    chk("in_ready_idle", in_ready[i], 1);
    in_valid[i]  = 1'b1;
    in_a[i]      = a;
    in_b[i]      = b;
    out_ready[i] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    k = 0;
    starts = 0;
    seen = 1'b0;
    hold_bad = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (core_start[i]) begin
        starts++;
        chk("core_start_cycle", k, 1);
        chk("core_a", core_a[i], a);
        chk("core_b", core_b[i], b);
      end
      if (core_a[i] !== a || core_b[i] !== b) hold_bad = 1'b1;
      if (out_valid[i]) seen = 1'b1;
    end
    chk("out_valid_latency", k, exp_lat);
    chk("core_start_count", starts, exp_core ? 1 : 0);
    chk("core_op_hold", hold_bad, 0);
    chk("out_gcd", out_gcd[i], exp_g);
    chk("out_err", out_err[i], exp_e);
    chk("out_a", out_a[i], a);
    chk("out_b", out_b[i], b);
    chk("in_ready_hold", in_ready[i], 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", out_valid[i], 1);
      chk("stall_gcd", out_gcd[i], exp_g);
      chk("stall_err", out_err[i], exp_e);
      chk("stall_a", out_a[i], a);
      chk("stall_in_ready", in_ready[i], 0);
    end
    out_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[i] = 1'b0;
    @(negedge clk);
    chk("valid_drop", out_valid[i], 0);
    chk("in_ready_back", in_ready[i], 1);
    chk("busy_clear", busy[i], 0);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_a[i]      = '0;
      in_b[i]      = '0;
      out_ready[i] = 1'b0;
      stray[i]     = 1'b0;
    end
    lat[0] = 7;
    lat[1] = 17;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_core_start", core_start[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_out_err", out_err[0], 0);
    chk("rst_out_gcd", out_gcd[0], 0);
    chk("rst_core_a", core_a[0], 0);
    rst = 1'b1;

    run_pair(0, 8'd48, 8'd18, 0, 8'd6,  1'b0, 10, 1'b1);
    run_pair(0, 8'd0,  8'd25, 0, 8'd25, 1'b0, 1,  1'b0);
    run_pair(0, 8'd17, 8'd0,  0, 8'd17, 1'b0, 1,  1'b0);
    run_pair(0, 8'd0,  8'd0,  0, 8'd0,  1'b1, 1,  1'b0);

    lat[0] = 0;
    run_pair(0, 8'd200, 8'd100, 0, 8'd0, 1'b1, 18, 1'b1);
    @(negedge clk);
    stray[0] = 1'b1;
    @(negedge clk);
    stray[0] = 1'b0;
    chk("stray_valid", out_valid[0], 0);
    chk("stray_busy", busy[0], 0);
    repeat (2) @(negedge clk);
    chk("stray_valid_late", out_valid[0], 0);
    lat[0] = 7;

    run_pair(1, 8'd255, 8'd85, 5, 8'd85, 1'b0, 20, 1'b1);

    @(negedge clk);
    in_valid[0] = 1'b1;
    in_a[0]     = 8'd12;
    in_b[0]     = 8'd8;
    @(posedge clk);
    #1;
    in_a[0] = 8'd9;
    in_b[0] = 8'd6;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy[0], 1);
    chk("mid_in_ready", in_ready[0], 0);
    rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid[0], 0);
    chk("arst_core_start", core_start[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_core_a", core_a[0], 0);
    chk("arst_out_b", out_b[0], 0);
    chk("arst_out_gcd", out_gcd[0], 0);
    chk("arst_out_err", out_err[0], 0);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_pair(0, 8'd9, 8'd6, 0, 8'd3, 1'b0, 10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
